imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Boot sequencer for the core's byte-wide instruction memory. Accepts 32-bit program words over a
//  valid/ready stream and writes each word as 4 little-endian byte writes into instr_mem.
//  Holds the core in reset until the program is loaded, then releases it.
//  Replaces testbench back-door loading with a synthesizable load path between the host/stream and core.
// PARAMETERS
//  ADDR_W     7   byte-address width of instr_mem (128 bytes)
//  MAX_WORDS  32  maximum words per load; reaching it without 'last' flags an error
//  BASE_ADDR  0   byte address of first written word (word aligned)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin a (re)load
//  word_in      in   32      program word
//  word_valid   in   1       word_in/word_last valid
//  word_last    in   1       current word is the final word of the program
//  word_ready   out  1       loader can accept a word this cycle
//  mem_we       out  1       instr_mem byte write enable
//  mem_addr     out  ADDR_W  instr_mem byte address
//  mem_wdata    out  8       instr_mem byte data
//  core_rst     out  1       active-high reset to core; 1 while loading
//  done         out  1       load complete, core running (sticky until next start)
//  err          out  1       MAX_WORDS hit without word_last (sticky until next start)
//  word_count   out  6       words written in current load
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1,
//    done=0, err=0, word_count=0. Mid-load reset aborts; already-written memory bytes are not cleared.
//  - States: IDLE -> LOAD -> WRITE -> (LOAD | DONE); DONE -> LOAD on start.
//  - IDLE: core_rst=1. start=1 -> LOAD, word_count=0, err=0, done=0.
//  - LOAD: word_ready=1 (registered). On word_valid&&word_ready: capture word_in and word_last,
//    word_ready=0 next cycle, enter WRITE with byte_idx=0. No accept while word_valid=0.
//  - WRITE: 4 consecutive cycles, mem_we=1, mem_addr=BASE_ADDR+4*word_count+byte_idx (mod 2^ADDR_W),
//    mem_wdata=word[8*byte_idx+:8]; byte 0 = word[7:0] first. After byte_idx=3: word_count+1.
//    Then: word_last -> DONE; else word_count+1==MAX_WORDS -> DONE with err=1; else LOAD.
//  - Throughput: 5 cycles/word minimum (1 accept + 4 writes). Write of byte 0 occurs the cycle after accept.
//  - DONE: core_rst=0 and done=1 starting the cycle after the last byte write; mem_we=0, word_ready=0.
//  - start is ignored in LOAD/WRITE. start in DONE: core_rst=1 same edge, done=0, count cleared, -> LOAD.
//  - start in IDLE together with word_valid: word is not accepted in that cycle (ready still 0).
//  - mem_we=0 in every state except WRITE; mem_addr/mem_wdata hold last value when mem_we=0.
// CONFIGURATION
//  IMEM_LOAD_CHECKSUM_EN defined: extra output port checksum[31:0], the mod-2^32 sum of all accepted
//   words of the current load; cleared on start and reset; stable and final when done=1.
//  Not defined: no checksum port and no adder; all other behaviour identical.
// STRUCTURE
//  Shared defines header: state encodings (IDLE/LOAD/WRITE/DONE), BYTES_PER_WORD=4, byte-lane
//   constants; reused by data-memory loaders and the core.
//  One sub-module: byte_serializer (word capture register + 2-bit byte_idx counter, emits
//   byte/we/last_byte); FSM, address generation, count and reset control stay in the top.
// TESTING
//  1. Reset: rst=0 at arbitrary time -> all outputs at reset values; core_rst=1.
//  2. start; stream 9 words, word 8 with last -> 36 byte writes at addr 0..35, mem[0]=word0[7:0],
//     mem[3]=word0[31:24]; done=1, core_rst=0, word_count=9, err=0.
//  3. word_valid toggling 1-of-3 cycles -> identical memory image, no duplicate/skipped words.
//  4. 32 words, none with last -> done=1, err=1, word_count=32, no 33rd accept.
//  5. Reset mid-WRITE of word 3 -> IDLE, core_rst=1; restart -> memory correct after full reload.
//  6. Reload from DONE with BASE_ADDR=16: start -> core_rst=1 same cycle; first write at addr 16;
//     with IMEM_LOAD_CHECKSUM_EN: words 1,2,0xFFFFFFFF -> checksum=0x00000002.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings, word/byte geometry and a byte-lane extraction helper.
// Data-memory loaders and the core reuse these.
package imem_boot_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int COUNT_W        = 6;

  localparam logic [1:0] BYTE_IDX_FIRST = 2'd0;
  localparam logic [1:0] BYTE_IDX_LAST  = 2'd3;

  // Little-endian byte lane select: lane 0 is word[7:0].
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_serializer.sv
// Word capture register plus 2-bit byte index. On load_i it captures a word
// and emits its four bytes (lane 0 first) on four consecutive cycles with
// we_o high. byte_o holds its last value while we_o is low.
module imem_boot_loader_byte_serializer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              we_o,
  output logic              last_byte_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic [BYTE_W-1:0] byte_q, byte_d;

  // Next-state: load a new word, step to the next lane, or stop after lane 3.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    we_d   = we_q;
    byte_d = byte_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = BYTE_IDX_FIRST;
      we_d   = 1'b1;
      byte_d = byte_lane(word_i, BYTE_IDX_FIRST);
    end else if (we_q && (idx_q != BYTE_IDX_LAST)) begin
      idx_d  = idx_q + 2'd1;
      byte_d = byte_lane(word_q, idx_q + 2'd1);
    end else if (we_q) begin
      we_d = 1'b0;
    end else begin
      we_d = 1'b0;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
      we_q   <= 1'b0;
      byte_q <= 8'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      we_q   <= we_d;
      byte_q <= byte_d;
    end
  end

  assign byte_o      = byte_q;
  assign we_o        = we_q;
  assign last_byte_o = we_q && (idx_q == BYTE_IDX_LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer for the byte-wide instruction memory. Accepts 32-bit words
// on a valid/ready stream, writes each as four little-endian byte writes and
// holds the core in reset until the program is loaded.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to add checksum_o, the
// mod-2^32 sum of all words accepted in the current load.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WORD_W-1:0]  word_in_i,
  input  logic               word_valid_i,
  input  logic               word_last_i,
  output logic               word_ready_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BYTE_W-1:0]  mem_wdata_o,
  output logic               core_rst_o,
  output logic               done_o,
  output logic               err_o,
  output logic [COUNT_W-1:0] word_count_o
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]  checksum_o
`endif
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);

  state_e             state_q;
  logic               ready_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               last_q;
  logic               core_rst_q;
  logic               done_q;
  logic               err_q;
  logic [COUNT_W-1:0] count_q;

  logic               accept_s;
  logic               start_s;
  logic [ADDR_W-1:0]  word_addr_s;
  logic [COUNT_W-1:0] count_inc_s;
  logic [BYTE_W-1:0]  ser_byte_s;
  logic               ser_we_s;
  logic               ser_last_s;

  // start only matters when no load is in flight.
  assign start_s     = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept_s    = (state_q == ST_LOAD) && ready_q && word_valid_i;
  // Byte address of lane 0 of the word being accepted, wrapping at 2^ADDR_W.
  assign word_addr_s = ADDR_W'(BASE_ADDR) + ADDR_W'({count_q, 2'b00});
  assign count_inc_s = count_q + 6'd1;

  imem_boot_loader_byte_serializer u_ser (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept_s),
    .word_i      (word_in_i),
    .byte_o      (ser_byte_s),
    .we_o        (ser_we_s),
    .last_byte_o (ser_last_s)
  );

  // Load sequencer: handshake, address generation, word count and core reset control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            state_q    <= ST_LOAD;
            ready_q    <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 6'd0;
          end else begin
            ready_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            last_q  <= word_last_i;
            addr_q  <= word_addr_s;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (ser_last_s) begin
            count_q <= count_inc_s;
            if (last_q) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else if (count_inc_s == MAX_CNT) begin
              // Buffer full without an end marker: stop and flag it.
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
              ready_q <= 1'b1;
            end
          end else if (ser_we_s) begin
            addr_q <= addr_q + 7'(1);
          end else begin
            addr_q <= addr_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b0;
          core_rst_q <= 1'b1;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q;

  // Running sum of accepted words, cleared when a new load begins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checksum_q <= 32'd0;
    end else if (start_s) begin
      checksum_q <= 32'd0;
    end else if (accept_s) begin
      checksum_q <= checksum_q + word_in_i;
    end else begin
      checksum_q <= checksum_q;
    end
  end

  assign checksum_o = checksum_q;
`endif

  assign word_ready_o = ready_q;
  assign mem_we_o     = ser_we_s;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = ser_byte_s;
  assign core_rst_o   = core_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = count_q;

endmodule
